// File: rtl/control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : control_unit_pipe
// Brief    : Multi-lane RV32 decode with one registered output stage, a
//            split/unified mode FSM and saturating per-lane branch counters.
// Revision : 1.0
// ============================================================================
module control_unit_pipe #(
  parameter int LANES = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7*LANES-1:0]     opcode,
  input  logic [3*LANES-1:0]     funct3,
  input  logic [7*LANES-1:0]     funct7,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3*LANES-1:0]     alu_op,
  output logic [2*LANES-1:0]     alu_ctrl,
  output logic [LANES-1:0]       alu_src,
  output logic [LANES-1:0]       mem_write,
  output logic [LANES-1:0]       branch,
  output logic [3*LANES-1:0]     branch_type,
  output logic [LANES-1:0]       illegal,
  output logic                   active_mode,
  output logic [CNT_W*LANES-1:0] branch_cnt
);

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_I      = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_SWITCH = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [3*LANES-1:0] w_op;
  logic [2*LANES-1:0] w_ctrl;
  logic [3*LANES-1:0] w_op_sel;
  logic [2*LANES-1:0] w_ctrl_sel;
  logic [LANES-1:0]   w_src;
  logic [LANES-1:0]   w_mw;
  logic [LANES-1:0]   w_br;
  logic [3*LANES-1:0] w_bt;
  logic [LANES-1:0]   w_ill;
  logic               w_accept;
  logic               w_unused;

  // Only funct7[5] of each lane matters to this decoder.
  assign w_unused = ^funct7;

  function automatic logic [2:0] f_alu_op(input logic [2:0] f3);
    case (f3)
      3'b000:  f_alu_op = 3'b000;
      3'b111:  f_alu_op = 3'b001;
      3'b110:  f_alu_op = 3'b010;
      3'b100:  f_alu_op = 3'b011;
      3'b001:  f_alu_op = 3'b100;
      3'b101:  f_alu_op = 3'b101;
      3'b010:  f_alu_op = 3'b110;
      default: f_alu_op = 3'b111;
    endcase
  endfunction

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic [2:0] w_op_l;
    logic [1:0] w_ctrl_l;
    logic       w_src_l;
    logic       w_mw_l;
    logic       w_br_l;
    logic [2:0] w_bt_l;
    logic       w_ill_l;

    assign w_opc  = opcode[7*gi +: 7];
    assign w_f3   = funct3[3*gi +: 3];
    assign w_f7b5 = funct7[7*gi + 5];

    always_comb begin
      w_op_l   = 3'b000;
      w_ctrl_l = 2'b00;
      w_src_l  = 1'b0;
      w_mw_l   = 1'b0;
      w_br_l   = 1'b0;
      w_bt_l   = 3'b000;
      w_ill_l  = 1'b0;
      case (w_opc)
        C_OP_R, C_OP_I: begin
          w_op_l  = f_alu_op(w_f3);
          w_src_l = (w_opc == C_OP_I);
          if (w_f3 == 3'b101)
            w_ctrl_l = w_f7b5 ? 2'b11 : 2'b10;
          else if ((w_opc == C_OP_R) && (w_f3 == 3'b000) && w_f7b5)
            w_ctrl_l = 2'b01;
        end
        C_OP_LOAD, C_OP_JALR: w_src_l = 1'b1;
        C_OP_STORE: begin
          w_src_l = 1'b1;
          w_mw_l  = 1'b1;
        end
        C_OP_BRANCH: begin
          w_br_l = 1'b1;
          case (w_f3)
            3'b000:  w_bt_l = 3'b000;
            3'b001:  w_bt_l = 3'b001;
            3'b100:  w_bt_l = 3'b010;
            3'b101:  w_bt_l = 3'b011;
            3'b110:  w_bt_l = 3'b100;
            3'b111:  w_bt_l = 3'b101;
            default: begin
              w_br_l  = 1'b0;
              w_ill_l = 1'b1;
            end
          endcase
        end
        default: w_ill_l = 1'b1;
      endcase
    end

    assign w_op[3*gi +: 3]   = w_op_l;
    assign w_ctrl[2*gi +: 2] = w_ctrl_l;
    assign w_src[gi]         = w_src_l;
    assign w_mw[gi]          = w_mw_l;
    assign w_br[gi]          = w_br_l;
    assign w_bt[3*gi +: 3]   = w_bt_l;
    assign w_ill[gi]         = w_ill_l;

    // Unified mode gangs the ALU to lane 0; an illegal lane still reads all-zero.
    assign w_op_sel[3*gi +: 3]   = (active_mode && !w_ill_l) ? w_op[2:0]   : w_op_l;
    assign w_ctrl_sel[2*gi +: 2] = (active_mode && !w_ill_l) ? w_ctrl[1:0] : w_ctrl_l;
  end

  // A pending mode change blocks intake immediately, before the FSM leaves RUN.
  assign in_ready = rst_n && (r_state == S_RUN) && (mode == active_mode) &&
                    (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (mode != active_mode) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (!out_valid || out_ready) w_state_nxt = S_SWITCH;
      S_SWITCH: w_state_nxt = S_RUN;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      active_mode <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_SWITCH)
        active_mode <= mode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_op      <= '0;
      alu_ctrl    <= '0;
      alu_src     <= '0;
      mem_write   <= '0;
      branch      <= '0;
      branch_type <= '0;
      illegal     <= '0;
      branch_cnt  <= '0;
    end else begin
      if (w_accept) begin
        out_valid   <= 1'b1;
        alu_op      <= w_op_sel;
        alu_ctrl    <= w_ctrl_sel;
        alu_src     <= w_src;
        mem_write   <= w_mw;
        branch      <= w_br;
        branch_type <= w_bt;
        illegal     <= w_ill;
        for (int i = 0; i < LANES; i++) begin
          if (w_br[i] && (branch_cnt[CNT_W*i +: CNT_W] != {CNT_W{1'b1}}))
            branch_cnt[CNT_W*i +: CNT_W] <= branch_cnt[CNT_W*i +: CNT_W] + C_CNT_ONE;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit_pipe
// Brief    : Self-checking bench for control_unit_pipe (LANES=2, CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_control_unit_pipe;

  localparam int LANES = 2;
  localparam int CNT_W = 4;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_JALR = 7'b1100111, OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [13:0] opcode = '0, funct7 = '0;
  logic [5:0]  funct3 = '0;
  logic        in_ready, out_valid, active_mode;
  logic [5:0]  alu_op, branch_type;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src, mem_write, branch, illegal;
  logic [7:0]  branch_cnt;

  typedef struct packed {
    logic [5:0] aop;
    logic [3:0] ctl;
    logic [1:0] src;
    logic [1:0] mw;
    logic [1:0] br;
    logic [5:0] bt;
    logic [1:0] ill;
  } bundle_t;

  bundle_t got;
  assign got = {alu_op, alu_ctrl, alu_src, mem_write, branch, branch_type, illegal};

  int      n_vec = 0, n_err = 0;
  bit      exp_valid = 0, exp_active = 0;
  bundle_t exp_b = '0;
  int      exp_cnt[2] = '{0, 0};

  control_unit_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
    .mem_write(mem_write), .branch(branch), .branch_type(branch_type), .illegal(illegal),
    .active_mode(active_mode), .branch_cnt(branch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decode built from the opcode/funct tables.
  function automatic bundle_t model_decode(input logic [13:0] opc, input logic [5:0] f3v,
                                           input logic [13:0] f7v, input bit uni);
    int aop_tbl[8] = '{0, 4, 6, 7, 3, 5, 2, 1};
    int bt_tbl[8]  = '{0, 1, -1, -1, 2, 3, 4, 5};
    int ao[2], ac[2], bt[2];
    bit src[2], mw[2], br[2], il[2];
    bundle_t b;
    for (int l = 0; l < 2; l++) begin
      logic [6:0] o;
      int f;
      bit s;
      o = opc[7*l +: 7];
      f = int'(f3v[3*l +: 3]);
      s = f7v[7*l + 5];
      ao[l] = 0; ac[l] = 0; bt[l] = 0; src[l] = 0; mw[l] = 0; br[l] = 0; il[l] = 0;
      if (o == OP_R || o == OP_I) begin
        ao[l]  = aop_tbl[f];
        src[l] = (o == OP_I);
        if (f == 5) ac[l] = s ? 3 : 2;
        else if (o == OP_R && f == 0 && s) ac[l] = 1;
      end else if (o == OP_LD || o == OP_JALR) begin
        src[l] = 1;
      end else if (o == OP_ST) begin
        src[l] = 1; mw[l] = 1;
      end else if (o == OP_BR) begin
        if (bt_tbl[f] < 0) il[l] = 1;
        else begin br[l] = 1; bt[l] = bt_tbl[f]; end
      end else begin
        il[l] = 1;
      end
    end
    if (uni) begin
      for (int l = 0; l < 2; l++)
        if (!il[l]) begin ao[l] = ao[0]; ac[l] = ac[0]; end
    end
    b = '0;
    for (int l = 0; l < 2; l++) begin
      b.aop[3*l +: 3] = 3'(ao[l]);
      b.ctl[2*l +: 2] = 2'(ac[l]);
      b.bt[3*l +: 3]  = 3'(bt[l]);
      b.src[l] = src[l]; b.mw[l] = mw[l]; b.br[l] = br[l]; b.ill[l] = il[l];
    end
    return b;
  endfunction

  function automatic bit model_ready();
    return (mode == exp_active) && (!exp_valid || out_ready);
  endfunction

  function automatic logic [7:0] exp_cnt_vec();
    return {4'(exp_cnt[1]), 4'(exp_cnt[0])};
  endfunction

  task automatic model_reset();
    exp_valid = 0; exp_active = 0; exp_b = '0; exp_cnt[0] = 0; exp_cnt[1] = 0;
  endtask

  // One clock edge in RUN state; advances the reference model alongside.
  task automatic tick();
    bit acc;
    bundle_t nb;
    acc = in_valid && model_ready();
    nb  = model_decode(opcode, funct3, funct7, exp_active);
    @(posedge clk);
    if (acc) begin
      exp_valid = 1; exp_b = nb;
      for (int l = 0; l < 2; l++)
        if (nb.br[l] && exp_cnt[l] < 15) exp_cnt[l]++;
    end else if (out_ready) begin
      exp_valid = 0;
    end
    #1;
  endtask

  task automatic rand_inputs(input bit legal_only);
    logic [6:0] ops[7];
    ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD; ops[3] = OP_ST;
    ops[4] = OP_JALR; ops[5] = OP_BR; ops[6] = OP_BAD;
    for (int l = 0; l < 2; l++)
      opcode[7*l +: 7] = ops[$urandom_range(legal_only ? 5 : 6, 0)];
    funct3 = 6'($urandom);
    funct7 = 14'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0; mode = 0; in_valid = 1; out_ready = 1;
    opcode = {OP_LD, OP_R}; funct3 = '0; funct7 = '0;
    #2;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, active_mode, got, branch_cnt} !== '0) begin
      n_err++; $display("FAIL reset_state got=%b/%b/%h/%h exp=0", out_valid, active_mode, got, branch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL first_ready got=%b exp=1", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, got} !== {1'b1, exp_b}) begin
      n_err++; $display("FAIL first_accept got=%b/%h exp=1/%h", out_valid, got, exp_b);
    end
  endtask

  task automatic test_split_vector();
    in_valid = 1; out_ready = 1;
    opcode = {OP_I, OP_R}; funct3 = {3'b000, 3'b101}; funct7 = {7'b0000000, 7'b0100000};
    tick();
    n_vec++;
    if ({alu_op, alu_ctrl, alu_src} !== {6'b000101, 4'b0011, 2'b10}) begin
      n_err++; $display("FAIL split_vec got=%b/%b/%b exp=000101/0011/10", alu_op, alu_ctrl, alu_src);
    end
    n_vec++; if (got !== exp_b) begin n_err++; $display("FAIL split_model got=%h exp=%h", got, exp_b); end
  endtask

  task automatic test_branch();
    int c0, c1;
    c0 = exp_cnt[0]; c1 = exp_cnt[1];
    in_valid = 1; out_ready = 1;
    opcode = {OP_BR, OP_BR}; funct3 = {3'b100, 3'b111}; funct7 = '0;
    tick();
    n_vec++;
    if ({branch, branch_type} !== {2'b11, 6'b010101}) begin
      n_err++; $display("FAIL branch_decode got=%b/%b exp=11/010101", branch, branch_type);
    end
    n_vec++;
    if (branch_cnt !== {4'(c1 + 1), 4'(c0 + 1)}) begin
      n_err++; $display("FAIL branch_cnt_inc got=%h exp=%h", branch_cnt, {4'(c1 + 1), 4'(c0 + 1)});
    end
  endtask

  task automatic test_saturation();
    int c0, c1;
    c0 = exp_cnt[0]; c1 = exp_cnt[1];
    in_valid = 1; out_ready = 1;
    opcode = {OP_I, OP_BR}; funct3 = {3'b000, 3'b000}; funct7 = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_vec++;
      if (branch_cnt !== {4'(c1), 4'((c0 + k > 15) ? 15 : c0 + k)}) begin
        n_err++; $display("FAIL sat_step%0d got=%h exp_lane0=%0d", k, branch_cnt, (c0 + k > 15) ? 15 : c0 + k);
      end
    end
    n_vec++; if (branch_cnt[3:0] !== 4'd15) begin n_err++; $display("FAIL sat_final got=%0d exp=15", branch_cnt[3:0]); end
  endtask

  task automatic test_illegal();
    in_valid = 1; out_ready = 1;
    opcode = {OP_BAD, OP_ST}; funct3 = 6'b111010; funct7 = 14'h3fff;
    tick();
    n_vec++; if (illegal !== 2'b10) begin n_err++; $display("FAIL illegal_flag got=%b exp=10", illegal); end
    n_vec++;
    if ({alu_op[5:3], alu_ctrl[3:2], alu_src[1], mem_write[1], branch[1], branch_type[5:3]} !== '0) begin
      n_err++; $display("FAIL illegal_lane1_zero got=%h exp=0", got);
    end
    n_vec++;
    if ({alu_src[0], mem_write[0], illegal[0]} !== 3'b110) begin
      n_err++; $display("FAIL illegal_lane0 got=%b%b%b exp=110", alu_src[0], mem_write[0], illegal[0]);
    end
  endtask

  task automatic test_backpressure();
    bundle_t a;
    in_valid = 1; out_ready = 1;
    opcode = {OP_ST, OP_I}; funct3 = {3'b010, 3'b100}; funct7 = '0;
    tick();
    a = exp_b;
    out_ready = 0;
    opcode = {OP_JALR, OP_R}; funct3 = {3'b000, 3'b010}; funct7 = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready%0d got=%b exp=0", k, in_ready); end
      tick();
      n_vec++;
      if ({out_valid, got} !== {1'b1, a}) begin
        n_err++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, out_valid, got, a);
      end
    end
    out_ready = 1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, got} !== {1'b1, model_decode({OP_JALR, OP_R}, {3'b000, 3'b010}, '0, 0)}) begin
      n_err++; $display("FAIL bp_next_bundle got=%b/%h", out_valid, got);
    end
    in_valid = 0;
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_random(input int cycles, input bit legal_only);
    for (int k = 0; k < cycles; k++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(3, 0) != 0);
      rand_inputs(legal_only);
      #1;
      n_vec++;
      if (in_ready !== model_ready()) begin
        n_err++; $display("FAIL rand_ready@%0d got=%b exp=%b", k, in_ready, model_ready());
      end
      tick();
      n_vec++;
      if ({out_valid, got} !== {exp_valid, exp_b}) begin
        n_err++; $display("FAIL rand_out@%0d got=%b/%h exp=%b/%h", k, out_valid, got, exp_valid, exp_b);
      end
      n_vec++;
      if (branch_cnt !== exp_cnt_vec()) begin
        n_err++; $display("FAIL rand_cnt@%0d got=%h exp=%h", k, branch_cnt, exp_cnt_vec());
      end
    end
  endtask

  task automatic test_mode_switch();
    mode = 0; in_valid = 1; out_ready = 1; rand_inputs(1);
    tick();
    out_ready = 0; in_valid = 0; mode = 1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ms_req_ready got=%b exp=0", in_ready); end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({in_ready, active_mode, out_valid} !== 3'b001) begin
        n_err++; $display("FAIL ms_drain%0d got=%b%b%b exp=001", k, in_ready, active_mode, out_valid);
      end
    end
    out_ready = 1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL ms_drain_rel got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    exp_valid = 0;
    n_vec++;
    if ({in_ready, active_mode, out_valid} !== 3'b000) begin
      n_err++; $display("FAIL ms_switch got=%b%b%b exp=000", in_ready, active_mode, out_valid);
    end
    @(posedge clk); #1;
    exp_active = 1;
    n_vec++;
    if ({in_ready, active_mode} !== 2'b11) begin
      n_err++; $display("FAIL ms_run got=%b%b exp=11", in_ready, active_mode);
    end
    in_valid = 1;
    opcode = {OP_R, OP_R}; funct3 = {3'b111, 3'b000}; funct7 = {7'b0000000, 7'b0100000};
    tick();
    n_vec++;
    if ({alu_op, alu_ctrl} !== {6'b000000, 4'b0101}) begin
      n_err++; $display("FAIL unified_vec got=%b/%b exp=000000/0101", alu_op, alu_ctrl);
    end
    test_random(100, 1);
  endtask

  task automatic test_revert();
    mode = 1; in_valid = 1; out_ready = 1; rand_inputs(1);
    tick();
    in_valid = 0; out_ready = 0; mode = 0;
    @(posedge clk); #1;
    mode = 1;
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rv_drain_ready got=%b exp=0", in_ready); end
    out_ready = 1;
    @(posedge clk); #1;
    exp_valid = 0;
    n_vec++;
    if ({in_ready, active_mode, out_valid} !== 3'b010) begin
      n_err++; $display("FAIL rv_switch got=%b%b%b exp=010", in_ready, active_mode, out_valid);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({in_ready, active_mode} !== 2'b11) begin
      n_err++; $display("FAIL rv_run got=%b%b exp=11", in_ready, active_mode);
    end
  endtask

  task automatic test_reset_mid_drain();
    in_valid = 1; out_ready = 1; rand_inputs(1);
    tick();
    in_valid = 0; out_ready = 0; mode = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    n_vec++;
    if ({out_valid, active_mode, in_ready} !== 3'b000) begin
      n_err++; $display("FAIL rst_async got=%b%b%b exp=000", out_valid, active_mode, in_ready);
    end
    n_vec++;
    if ({got, branch_cnt} !== '0) begin
      n_err++; $display("FAIL rst_fields got=%h/%h exp=0", got, branch_cnt);
    end
    @(posedge clk); #2;
    rst_n = 1;
    model_reset();
    in_valid = 1; out_ready = 1; rand_inputs(1);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_ready got=%b exp=1", in_ready); end
    tick();
    n_vec++;
    if ({out_valid, got} !== {1'b1, exp_b}) begin
      n_err++; $display("FAIL rst_rel_accept got=%b/%h exp=1/%h", out_valid, got, exp_b);
    end
  endtask

  initial begin
    test_reset();
    test_split_vector();
    test_branch();
    test_saturation();
    test_illegal();
    test_backpressure();
    test_random(200, 0);
    test_mode_switch();
    test_revert();
    test_reset_mid_drain();
    test_random(100, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
